ecall_io_ctrl: RTL and testbench



---
 rtl/ecall_pkg.sv | 7 +
 rtl/button_debounce.sv | 32 +++
 rtl/ecall_io_ctrl.sv | 100 ++++++++++
 tb/tb_ecall_io_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ecall_pkg.sv
// ecall_pkg: service codes and sequencer states for the ecall I/O controller
package ecall_pkg;
  localparam int unsigned SVC_PRINT = 1;
  localparam int unsigned SVC_READ  = 5;
  localparam int unsigned SVC_EXIT  = 10;
  typedef enum logic [2:0] {IDLE, WAIT_REL, WAIT_PRESS, COMMIT, RESUME, HALT} state_t;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: synchronises a raw button, filters it and emits a one-cycle press pulse
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 230000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q, press_q, done;
  assign done    = (sync_q[1] != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  assign level_o = level_q;
  assign press_o = press_q;
  // synchroniser, run-length counter of differing samples, filtered level and its rising edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= (sync_q[1] == level_q || done) ? '0 : cnt_q + 1'b1;
      level_q <= done ? sync_q[1] : level_q;
      press_q <= done & sync_q[1];
    end
  end
endmodule

// File: rtl/ecall_io_ctrl.sv
// ecall_io_ctrl: holds the PC during ecall services and drives switch reads, prints and exit
module ecall_io_ctrl
  import ecall_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 230000,
  parameter int DATA_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ecall,
  input  logic [DATA_W-1:0] a7_data,
  input  logic [DATA_W-1:0] a0_data,
  input  logic [7:0]        sw_in,
  input  logic              confirm_button,
  output logic              pc_hold,
  output logic              a0_we,
  output logic [DATA_W-1:0] a0_wdata,
  output logic [7:0]        led_out,
  output logic [DATA_W-1:0] disp_value,
  output logic              disp_valid,
  output logic              halted
);
  state_t            state_q, state_d;
  logic              read_q, read_d;
  logic [DATA_W-1:0] a0_wdata_q, a0_wdata_d, disp_value_q, disp_value_d;
  logic [7:0]        led_q, led_d;
  logic              disp_valid_q, disp_valid_d;
  logic              btn_level, btn_press;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (confirm_button),
    .level_o (btn_level),
    .press_o (btn_press)
  );

  // the hold is combinational so the PC never passes the ecall; all strobes are quiet in reset
  assign pc_hold    = ~reset & ((state_q == IDLE) ? ecall : (state_q != RESUME));
  assign a0_we      = ~reset & (state_q == COMMIT);
  assign halted     = ~reset & (state_q == HALT);
  assign a0_wdata   = a0_wdata_q;
  assign led_out    = led_q;
  assign disp_value = disp_value_q;
  assign disp_valid = disp_valid_q;

  // next state: the service kind is latched at entry so a7 may change while waiting
  always_comb begin
    state_d      = state_q;
    read_d       = read_q;
    a0_wdata_d   = a0_wdata_q;
    led_d        = led_q;
    disp_value_d = disp_value_q;
    disp_valid_d = disp_valid_q;
    unique case (state_q)
      IDLE: if (ecall) begin
        if (a7_data == DATA_W'(SVC_PRINT)) begin
          disp_value_d = a0_data;
          led_d        = a0_data[7:0];
          disp_valid_d = 1'b1;
          read_d       = 1'b0;
          state_d      = WAIT_REL;
        end else if (a7_data == DATA_W'(SVC_READ)) begin
          read_d  = 1'b1;
          state_d = WAIT_REL;
        end else begin
          state_d = (a7_data == DATA_W'(SVC_EXIT)) ? HALT : RESUME;
        end
      end
      WAIT_REL:   state_d = btn_level ? WAIT_REL : WAIT_PRESS;
      WAIT_PRESS: if (btn_press) begin
        a0_wdata_d = read_q ? DATA_W'(sw_in) : a0_wdata_q;
        state_d    = read_q ? COMMIT : RESUME;
      end
      COMMIT:  state_d = RESUME;
      RESUME:  state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      read_q       <= 1'b0;
      a0_wdata_q   <= '0;
      led_q        <= '0;
      disp_value_q <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      a0_wdata_q   <= a0_wdata_d;
      led_q        <= led_d;
      disp_value_q <= disp_value_d;
      disp_valid_q <= disp_valid_d;
    end
  end
endmodule

// File: tb/tb_ecall_io_ctrl.sv
// tb_ecall_io_ctrl: directed checks of the ecall sequencer with a 4-sample debouncer
module tb_ecall_io_ctrl;
  logic        clk = 1'b0, reset = 1'b1, ecall = 1'b0, confirm_button = 1'b0;
  logic [31:0] a7_data = '0, a0_data = '0;
  logic [7:0]  sw_in = '0;
  logic        pc_hold, a0_we, disp_valid, halted;
  logic [31:0] a0_wdata, disp_value;
  logic [7:0]  led_out;
  int          checks = 0, failures = 0;

  ecall_io_ctrl #(.DEBOUNCE_CYCLES(4), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .ecall(ecall), .a7_data(a7_data), .a0_data(a0_data),
    .sw_in(sw_in), .confirm_button(confirm_button), .pc_hold(pc_hold), .a0_we(a0_we),
    .a0_wdata(a0_wdata), .led_out(led_out), .disp_value(disp_value),
    .disp_valid(disp_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // press for six cycles starting now; a read commits on the 7th edge and resumes on the 8th
  task automatic press_read(input logic [31:0] exp_data);
    confirm_button = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 6) confirm_button = 1'b0;
      check("read_we", a0_we, (i == 7));
      check("read_hold", pc_hold, (i != 8));
      if (i == 7) check("read_wdata", a0_wdata, exp_data);
    end
    ecall = 1'b0;
    tick();
    check("read_idle_hold", pc_hold, 0);
  endtask

  initial begin
    ecall = 1'b1;
    idle(3);
    check("rst_hold", pc_hold, 0);
    check("rst_we", a0_we, 0);
    check("rst_wdata", a0_wdata, 0);
    check("rst_led", led_out, 0);
    check("rst_disp", disp_value, 0);
    check("rst_valid", disp_valid, 0);
    check("rst_halted", halted, 0);
    ecall = 1'b0;
    reset = 1'b0;
    tick();
    check("idle_hold", pc_hold, 0);

    a7_data = 5; sw_in = 8'hA5; ecall = 1'b1;
    #1 check("read_entry_hold", pc_hold, 1);
    tick();
    check("read_wrel_hold", pc_hold, 1);
    tick();
    press_read(32'h0000_00A5);
    idle(10);

    a7_data = 1; a0_data = 32'h1234; ecall = 1'b1;
    #1 check("print_entry_hold", pc_hold, 1);
    tick();
    a7_data = 5; a0_data = 32'h9999;
    check("print_disp", disp_value, 32'h1234);
    check("print_led", led_out, 8'h34);
    check("print_valid", disp_valid, 1);
    tick();
    confirm_button = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 6) confirm_button = 1'b0;
      check("print_we", a0_we, 0);
      check("print_hold", pc_hold, (i != 7));
    end
    ecall = 1'b0;
    idle(10);

    confirm_button = 1'b1;
    idle(10);
    a7_data = 5; sw_in = 8'h3C; ecall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("held_we", a0_we, 0);
      check("held_hold", pc_hold, 1);
    end
    confirm_button = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rel_we", a0_we, 0);
    end
    confirm_button = 1'b1;
    idle(3);
    confirm_button = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("glitch_we", a0_we, 0);
      check("glitch_hold", pc_hold, 1);
    end
    press_read(32'h0000_003C);
    check("read_keeps_disp", disp_value, 32'h1234);
    check("read_keeps_valid", disp_valid, 1);
    idle(10);

    a7_data = 7; ecall = 1'b1;
    #1 check("unk_entry_hold", pc_hold, 1);
    tick();
    check("unk_resume_hold", pc_hold, 0);
    check("unk_we", a0_we, 0);
    check("unk_disp", disp_value, 32'h1234);
    check("unk_led", led_out, 8'h34);
    ecall = 1'b0;
    tick();
    check("unk_idle_hold", pc_hold, 0);

    a7_data = 5; sw_in = 8'h77; ecall = 1'b1;
    idle(2);
    check("mid_hold", pc_hold, 1);
    confirm_button = 1'b1;
    idle(2);
    reset = 1'b1;
    tick();
    check("mid_rst_hold", pc_hold, 0);
    check("mid_rst_disp", disp_value, 0);
    check("mid_rst_led", led_out, 0);
    check("mid_rst_valid", disp_valid, 0);
    check("mid_rst_wdata", a0_wdata, 0);
    reset = 1'b0; ecall = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("post_rst_we", a0_we, 0);
      check("post_rst_hold", pc_hold, 0);
    end
    confirm_button = 1'b0;
    idle(10);

    a7_data = 10; ecall = 1'b1;
    #1 check("exit_entry_hold", pc_hold, 1);
    tick();
    for (int i = 0; i < 100; i++) begin
      confirm_button = (i % 10) < 6;
      ecall = i[3];
      tick();
      check("exit_halted", halted, 1);
      check("exit_hold", pc_hold, 1);
      check("exit_we", a0_we, 0);
    end
    reset = 1'b1;
    tick();
    check("exit_rst_halted", halted, 0);
    reset = 1'b0; ecall = 1'b0; confirm_button = 1'b0;
    tick();
    check("exit_rst_idle_halted", halted, 0);
    check("exit_rst_idle_hold", pc_hold, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
